// File: rtl/sequenciador_pilha_rpn.sv
// RPN operand stack and dispatch sequencer: LIFO operands, 1-cycle ADD/SUB,
// MUL handed to the external iterative saturating multiplier.
// Ports: CLOCK, RESET (sync, high); push/command inputs Entrada, Empilhar,
//   Operar, Codigo; status Topo, Nivel, Ocupado, Overflow, Erro;
//   multiplier side Mult_A, Mult_B, Mult_START, Mult_Resultado,
//   Mult_Overflow, Mult_Pronto.
// Optional macro WATCHDOG_EN: abort a MUL after LIMITE_ESPERA wait cycles.
module sequenciador_pilha_rpn #(
  parameter int PROFUNDIDADE  = 4,
  parameter int LIMITE_ESPERA = 300
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [7:0] Entrada,
  input  logic       Empilhar,
  input  logic       Operar,
  input  logic [1:0] Codigo,
  output logic [7:0] Topo,
  output logic [2:0] Nivel,
  output logic       Ocupado,
  output logic       Overflow,
  output logic       Erro,
  output logic [7:0] Mult_A,
  output logic [7:0] Mult_B,
  output logic       Mult_START,
  input  logic [7:0] Mult_Resultado,
  input  logic       Mult_Overflow,
  input  logic       Mult_Pronto
);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    DISPARO = 2'd1,
    ESPERA  = 2'd2
  } estado_t;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_DROP = 2'b11;

  estado_t estado;
  estado_t prox_estado;

  // pilha[0] is the top (B), pilha[1] the entry below it (A)
  logic [7:0] pilha [PROFUNDIDADE];
  logic [2:0] nivel;
  logic       ovf_q;
  logic       erro_q;
  logic [7:0] mult_a_q;
  logic [7:0] mult_b_q;

  logic       vazia;
  logic       cheia;
  logic       tem_dois;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [8:0] soma;

  logic       faz_push;
  logic       faz_bin;
  logic       faz_drop;
  logic       lanca_mul;
  logic       seta_erro;
  logic       carrega_ovf;
  logic       ovf_novo;
  logic [7:0] resultado;
  logic       estouro;

  assign vazia    = (nivel == 3'd0);
  assign cheia    = (nivel >= 3'(PROFUNDIDADE));
  assign tem_dois = (nivel >= 3'd2);
  assign op_b     = pilha[0];
  assign op_a     = pilha[1];
  assign soma     = {1'b0, op_a} + {1'b0, op_b};

`ifdef WATCHDOG_EN
  localparam int CNT_W = $clog2(LIMITE_ESPERA + 1);

  logic [CNT_W-1:0] espera_cnt;

  // Counts ESPERA cycles; index k holds value k
  always_ff @(posedge CLOCK) begin
    if (RESET || estado != ESPERA) begin
      espera_cnt <= '0;
    end else begin
      espera_cnt <= espera_cnt + 1'b1;
    end
  end

  assign estouro = (espera_cnt == CNT_W'(LIMITE_ESPERA - 1));
`else
  logic unused_limite;

  assign unused_limite = |32'(LIMITE_ESPERA);
  assign estouro       = 1'b0;
`endif

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      estado <= OCIOSO;
    end else begin
      estado <= prox_estado;
    end
  end

  always_comb begin
    prox_estado = estado;
    faz_push    = 1'b0;
    faz_bin     = 1'b0;
    faz_drop    = 1'b0;
    lanca_mul   = 1'b0;
    seta_erro   = 1'b0;
    carrega_ovf = 1'b0;
    ovf_novo    = 1'b0;
    resultado   = 8'd0;
    unique case (estado)
      OCIOSO: begin
        if (Operar) begin
          // a simultaneous push is discarded and flagged
          if (Empilhar) seta_erro = 1'b1;
          if (Codigo == OP_DROP) begin
            if (vazia) seta_erro = 1'b1;
            else       faz_drop  = 1'b1;
          end else if (!tem_dois) begin
            seta_erro = 1'b1;
          end else begin
            unique case (Codigo)
              OP_ADD: begin
                faz_bin     = 1'b1;
                carrega_ovf = 1'b1;
                ovf_novo    = soma[8];
                resultado   = soma[8] ? 8'hFF : soma[7:0];
              end
              OP_SUB: begin
                faz_bin     = 1'b1;
                carrega_ovf = 1'b1;
                ovf_novo    = (op_a < op_b);
                resultado   = (op_a < op_b) ? 8'd0 : op_a - op_b;
              end
              OP_MUL: begin
                lanca_mul   = 1'b1;
                prox_estado = DISPARO;
              end
              default: ;
            endcase
          end
        end else if (Empilhar) begin
          if (cheia) seta_erro = 1'b1;
          else       faz_push  = 1'b1;
        end
      end
      DISPARO: begin
        prox_estado = ESPERA;
      end
      ESPERA: begin
        if (Mult_Pronto) begin
          faz_bin     = 1'b1;
          carrega_ovf = 1'b1;
          ovf_novo    = Mult_Overflow;
          resultado   = Mult_Resultado;
          prox_estado = OCIOSO;
        end else if (estouro) begin
          // abandon the MUL with operands left in place
          seta_erro   = 1'b1;
          prox_estado = OCIOSO;
        end
      end
      default: begin
        prox_estado = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      nivel <= 3'd0;
      for (int i = 0; i < PROFUNDIDADE; i++) begin
        pilha[i] <= 8'd0;
      end
    end else if (faz_push) begin
      for (int i = PROFUNDIDADE - 1; i > 0; i--) begin
        pilha[i] <= pilha[i-1];
      end
      pilha[0] <= Entrada;
      nivel    <= nivel + 3'd1;
    end else if (faz_bin) begin
      // pop A and B, result takes A's slot
      pilha[0] <= resultado;
      for (int i = 1; i < PROFUNDIDADE - 1; i++) begin
        pilha[i] <= pilha[i+1];
      end
      pilha[PROFUNDIDADE-1] <= 8'd0;
      nivel <= nivel - 3'd1;
    end else if (faz_drop) begin
      for (int i = 0; i < PROFUNDIDADE - 1; i++) begin
        pilha[i] <= pilha[i+1];
      end
      pilha[PROFUNDIDADE-1] <= 8'd0;
      nivel <= nivel - 3'd1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      ovf_q    <= 1'b0;
      erro_q   <= 1'b0;
      mult_a_q <= 8'd0;
      mult_b_q <= 8'd0;
    end else begin
      if (carrega_ovf) ovf_q <= ovf_novo;
      if (seta_erro)   erro_q <= 1'b1;
      if (lanca_mul) begin
        mult_a_q <= op_a;
        mult_b_q <= op_b;
      end
    end
  end

  assign Topo       = vazia ? 8'd0 : pilha[0];
  assign Nivel      = nivel;
  assign Ocupado    = (estado != OCIOSO);
  assign Overflow   = ovf_q;
  assign Erro       = erro_q;
  assign Mult_A     = mult_a_q;
  assign Mult_B     = mult_b_q;
  assign Mult_START = (estado == DISPARO);

endmodule

// File: doc/sequenciador_pilha_rpn.md
Name: sequenciador_pilha_rpn

Overview:
Operand stack and dispatch sequencer for the 8-bit RPN ALU, sitting directly upstream of the iterative saturating multiplier. It takes user pushes and operation commands, holds operands in a LIFO, and computes ADD/SUB internally in one cycle. For MUL it drives the multiplier's A/B/START, waits for its Pronto, and pushes the saturated product back onto the stack.

Parameters:
PROFUNDIDADE, 4, stack depth in entries (2..7; Nivel is 3 bits).
LIMITE_ESPERA, 300, watchdog cycle limit while waiting for Mult_Pronto (used only with WATCHDOG_EN).

Ports:
CLOCK  in  1  system clock, rising edge.
RESET  in  1  synchronous, active-high reset.
Entrada  in  8  value to push.
Empilhar  in  1  push request, one-cycle pulse.
Operar  in  1  execute request, one-cycle pulse.
Codigo  in  2  operation: 00 ADD, 01 SUB, 10 MUL, 11 DROP.
Topo  out  8  top-of-stack value; 0 when empty.
Nivel  out  3  number of occupied entries.
Ocupado  out  1  high while a MUL is in flight.
Overflow  out  1  saturation flag of the last executed operation.
Erro  out  1  sticky error flag.
Mult_A  out  8  multiplicand to the multiplier (registered).
Mult_B  out  8  multiplier count to the multiplier (registered).
Mult_START  out  1  one-cycle start pulse to the multiplier.
Mult_Resultado  in  8  saturated product.
Mult_Overflow  in  1  multiplier saturation flag.
Mult_Pronto  in  1  multiplier done; combinational, may be stale before start.

Behaviour:
- Reset values: all outputs 0. Stack empty, FSM in OCIOSO. The multiplier shares RESET.
- Operand order: "A B op" means A op B. B is the top entry and A is the entry below it.
- FSM states: OCIOSO, DISPARO, ESPERA.
- OCIOSO, Empilhar with Nivel<PROFUNDIDADE: push Entrada; Nivel+1 at the same edge.
- OCIOSO, Empilhar with the stack full: Erro<=1; stack unchanged.
- OCIOSO, Operar with Nivel<2 (any code except DROP): Erro<=1; no change.
- OCIOSO, DROP with Nivel=0: Erro<=1; no change.
- Empilhar and Operar in the same cycle: Operar executes, Empilhar is dropped, Erro<=1.
- ADD: result = min(A+B, 255), computed with a 9-bit sum. Overflow=1 iff A+B>255.
- SUB: result = A-B if A>=B; otherwise result 0 and Overflow=1.
- ADD/SUB: pop 2, push result at the same edge; Nivel-1; no Ocupado.
- DROP: pop 1; Overflow is unchanged.
- MUL, issue: latch Mult_A<=A and Mult_B<=B, then go to DISPARO.
- DISPARO: lasts exactly 1 cycle with Mult_START=1 and Ocupado=1; then go to ESPERA.
- ESPERA, Ocupado=1: Mult_Pronto is ignored during DISPARO and sampled from the first ESPERA cycle on.
- ESPERA, on Mult_Pronto=1: pop 2, push Mult_Resultado, Overflow<=Mult_Overflow, return to OCIOSO.
- MUL timing: the result is captured in ESPERA cycle index B, 0-based. Ocupado is high for exactly B+2 cycles.
- Mult_A and Mult_B stay stable from issue until return to OCIOSO. The stack is frozen while Ocupado=1.
- Commands while Ocupado=1 are ignored silently (no Erro).
- Overflow is cleared or reloaded on every valid ADD/SUB/MUL. It stays cleared until the next operation.
- Erro is cleared only by RESET.
- RESET mid-MUL: back to OCIOSO, stack emptied, Mult_START=0, Ocupado=0 on the next cycle.

Optional Feature:
WATCHDOG_EN:
- Defined: a counter runs in ESPERA. If LIMITE_ESPERA cycles pass without Mult_Pronto, set Erro<=1 and return to OCIOSO. The stack and Overflow are unchanged and operands are not popped.
- Not defined: ESPERA waits indefinitely; LIMITE_ESPERA is unused.

Test Plan:
- Push 12, push 10, Operar MUL -> Mult_A=12, Mult_B=10, Mult_START high 1 cycle, Ocupado 12 cycles; then Topo=120, Nivel=1, Overflow=0.
- Push 20, 20 MUL -> Topo=255, Overflow=1. Push 7, 0 MUL -> Ocupado 2 cycles, Topo=0, Overflow=0.
- Push 200, 100 ADD -> Topo=255, Overflow=1. Push 5, 9 SUB -> Topo=0, Overflow=1. Push 9, 5 SUB -> Topo=4, Overflow=0.
- Five pushes with PROFUNDIDADE=4 -> Nivel=4, Erro=1, Topo=4th value. After RESET, a single push then ADD -> Erro=1, Nivel=1.
- Push 3, 200 MUL, assert RESET 50 cycles after Operar -> next cycle Nivel=0, Ocupado=0, Mult_START=0, Topo=0, Erro=0.
- WATCHDOG_EN, LIMITE_ESPERA=300, Mult_Pronto tied 0 -> Ocupado drops after 301 cycles, Erro=1, Nivel=2, stack intact.
